branch_predictor: RTL and testbench

Direct-mapped branch target buffer with 2-bit saturating direction counters, sitting directly upstream of the next-PC selector. It looks up the current fetch PC every cycle and drives `take_pre`/`Pre_Target`, which the next-PC logic uses when no exception, jump-register or mispredict redirect has priority. Resolved branches from EXE train the table one cycle later.

---
 rtl/branch_predictor.sv | 104 ++++++++++
 tb/tb_branch_predictor.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/branch_predictor.sv
`default_nettype none
// ============================================================================
//  Module      : branch_predictor
//  Description : Direct-mapped branch target buffer with 2-bit saturating
//                direction counters. Combinational lookup of the fetch PC;
//                resolved branches train the table on the next clock edge.
//  Revision    : 1.0 - initial release
// ============================================================================
module branch_predictor #(
    parameter int ENTRIES = 64,
    parameter int IDX_W   = 6
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] PC_IF,
    output logic        take_pre,
    output logic [31:0] Pre_Target,
    input  logic        upd_valid,
    input  logic [31:0] upd_PC,
    input  logic        upd_taken,
    input  logic [31:0] upd_target
);

    localparam int c_TAG_W = 32 - IDX_W - 2;

    localparam logic [1:0] c_CTR_STRONG_NT = 2'b00;
    localparam logic [1:0] c_CTR_WEAK_NT   = 2'b01;
    localparam logic [1:0] c_CTR_WEAK_T    = 2'b10;
    localparam logic [1:0] c_CTR_STRONG_T  = 2'b11;

    // Table storage: valid/ctr are reset, tag/target are not (RAM-friendly)
    logic [ENTRIES-1:0] r_valid;
    logic [1:0]         r_ctr    [ENTRIES];
    logic [c_TAG_W-1:0] r_tag    [ENTRIES];
    logic [29:0]        r_target [ENTRIES];

    logic [IDX_W-1:0]   w_lk_idx;
    logic [c_TAG_W-1:0] w_lk_tag;
    logic               w_lk_hit;

    logic [IDX_W-1:0]   w_up_idx;
    logic [c_TAG_W-1:0] w_up_tag;
    logic               w_up_hit;
    logic [1:0]         w_ctr_cur;
    logic [1:0]         w_ctr_next;

    // Byte-offset bits never take part in indexing or targets
    logic w_unused_low_bits;
    assign w_unused_low_bits = ^{PC_IF[1:0], upd_PC[1:0], upd_target[1:0]};

    assign w_lk_idx = PC_IF[IDX_W+1:2];
    assign w_lk_tag = PC_IF[31:IDX_W+2];
    assign w_up_idx = upd_PC[IDX_W+1:2];
    assign w_up_tag = upd_PC[31:IDX_W+2];

    // Lookup: pure function of the fetch PC and the registered table, so a
    // same-cycle update is only seen from the following cycle onward
    always_comb begin
        w_lk_hit   = r_valid[w_lk_idx] && (r_tag[w_lk_idx] == w_lk_tag);
        take_pre   = w_lk_hit && r_ctr[w_lk_idx][1];
        Pre_Target = w_lk_hit ? {r_target[w_lk_idx], 2'b00} : 32'h0;
    end

    // Training decode: hit detection and saturating next-counter value
    always_comb begin
        w_up_hit  = r_valid[w_up_idx] && (r_tag[w_up_idx] == w_up_tag);
        w_ctr_cur = r_ctr[w_up_idx];
        if (upd_taken) begin
            w_ctr_next = (w_ctr_cur == c_CTR_STRONG_T) ? c_CTR_STRONG_T
                                                       : w_ctr_cur + 2'd1;
        end else begin
            w_ctr_next = (w_ctr_cur == c_CTR_STRONG_NT) ? c_CTR_STRONG_NT
                                                        : w_ctr_cur - 2'd1;
        end
    end

    // Valid bits and counters: reset wins over a simultaneous update; a
    // not-taken miss leaves the entry (and any aliasing owner) untouched
    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid <= '0;
            for (int i = 0; i < ENTRIES; i++) begin
                r_ctr[i] <= c_CTR_WEAK_NT;
            end
        end else if (upd_valid) begin
            if (w_up_hit) begin
                r_ctr[w_up_idx] <= w_ctr_next;
            end else if (upd_taken) begin
                r_valid[w_up_idx] <= 1'b1;
                r_ctr[w_up_idx]   <= c_CTR_WEAK_T;
            end
        end
    end

    // Tag/target: any taken update (hit refresh or miss allocate) owns the entry
    always_ff @(posedge clk) begin
        if (!rst && upd_valid && upd_taken) begin
            r_tag[w_up_idx]    <= w_up_tag;
            r_target[w_up_idx] <= upd_target[31:2];
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_branch_predictor.sv
`default_nettype none
// ============================================================================
//  Module      : tb_branch_predictor
//  Description : Directed self-checking bench for branch_predictor.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_branch_predictor;

    logic        clk;
    logic        rst;
    logic [31:0] PC_IF;
    logic        take_pre;
    logic [31:0] Pre_Target;
    logic        upd_valid;
    logic [31:0] upd_PC;
    logic        upd_taken;
    logic [31:0] upd_target;

    int errors;
    int checks;

    branch_predictor #(
        .ENTRIES(64),
        .IDX_W  (6)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .PC_IF     (PC_IF),
        .take_pre  (take_pre),
        .Pre_Target(Pre_Target),
        .upd_valid (upd_valid),
        .upd_PC    (upd_PC),
        .upd_taken (upd_taken),
        .upd_target(upd_target)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one clock edge, leaving inputs settled 1 time unit after it
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present one resolved branch for exactly one edge
    task automatic train(input logic [31:0] pc, input logic taken, input logic [31:0] tgt);
        upd_valid  = 1'b1;
        upd_PC     = pc;
        upd_taken  = taken;
        upd_target = tgt;
        tick();
        upd_valid  = 1'b0;
        upd_taken  = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        for (int i = 0; i < 64; i++) begin
            PC_IF = 32'hbfc00000 + 32'(i * 4);
            #1;
            checks++;
            if (take_pre !== 1'b0 || Pre_Target !== 32'h0) begin
                errors++;
                $display("FAIL reset_sweep pc=%08h got take=%b tgt=%08h want take=0 tgt=00000000",
                         PC_IF, take_pre, Pre_Target);
            end
        end
    endtask

    task automatic test_allocate();
        upd_valid  = 1'b1;
        upd_PC     = 32'hbfc00010;
        upd_taken  = 1'b1;
        upd_target = 32'hbfc00100;
        PC_IF      = 32'hbfc00010;
        #1;
        checks++;
        if (take_pre !== 1'b0 || Pre_Target !== 32'h0) begin
            errors++;
            $display("FAIL alloc_same_cycle got take=%b tgt=%08h want take=0 tgt=00000000",
                     take_pre, Pre_Target);
        end
        tick();
        upd_valid = 1'b0;
        upd_taken = 1'b0;
        checks++;
        if (take_pre !== 1'b1 || Pre_Target !== 32'hbfc00100) begin
            errors++;
            $display("FAIL alloc_next_cycle got take=%b tgt=%08h want take=1 tgt=bfc00100",
                     take_pre, Pre_Target);
        end
    endtask

    task automatic test_saturation();
        // Counter walk from 10: NT,NT,NT,T,T,T,T,NT,NT,T
        logic [9:0] dir;
        logic [9:0] exp;
        dir = 10'b0001111001;
        exp = 10'b0000111101;
        PC_IF = 32'hbfc00010;
        for (int i = 0; i < 10; i++) begin
            train(32'hbfc00010, dir[9-i], 32'hbfc00100);
            checks++;
            if (take_pre !== exp[9-i] || (exp[9-i] && Pre_Target !== 32'hbfc00100)) begin
                errors++;
                $display("FAIL saturation step=%0d dir=%b got take=%b tgt=%08h want take=%b tgt=bfc00100",
                         i, dir[9-i], take_pre, Pre_Target, exp[9-i]);
            end
        end
    endtask

    task automatic test_aliasing();
        PC_IF = 32'hbfc00110;
        #1;
        checks++;
        if (take_pre !== 1'b0 || Pre_Target !== 32'h0) begin
            errors++;
            $display("FAIL alias_lookup got take=%b tgt=%08h want take=0 tgt=00000000", take_pre, Pre_Target);
        end
        train(32'hbfc00110, 1'b0, 32'hbfc00200);
        checks++;
        if (take_pre !== 1'b0 || Pre_Target !== 32'h0) begin
            errors++;
            $display("FAIL alias_nt_no_alloc got take=%b tgt=%08h want take=0 tgt=00000000", take_pre, Pre_Target);
        end
        PC_IF = 32'hbfc00010;
        #1;
        checks++;
        if (take_pre !== 1'b1 || Pre_Target !== 32'hbfc00100) begin
            errors++;
            $display("FAIL alias_owner_kept got take=%b tgt=%08h want take=1 tgt=bfc00100", take_pre, Pre_Target);
        end
        train(32'hbfc00110, 1'b1, 32'hbfc00200);
        PC_IF = 32'hbfc00110;
        #1;
        checks++;
        if (take_pre !== 1'b1 || Pre_Target !== 32'hbfc00200) begin
            errors++;
            $display("FAIL alias_replace got take=%b tgt=%08h want take=1 tgt=bfc00200", take_pre, Pre_Target);
        end
        PC_IF = 32'hbfc00010;
        #1;
        checks++;
        if (take_pre !== 1'b0 || Pre_Target !== 32'h0) begin
            errors++;
            $display("FAIL alias_evicted got take=%b tgt=%08h want take=0 tgt=00000000", take_pre, Pre_Target);
        end
    endtask

    task automatic test_target_rewrite();
        train(32'hbfc00110, 1'b1, 32'hbfc00303);
        PC_IF = 32'hbfc00110;
        #1;
        checks++;
        if (take_pre !== 1'b1 || Pre_Target !== 32'hbfc00300) begin
            errors++;
            $display("FAIL target_rewrite got take=%b tgt=%08h want take=1 tgt=bfc00300", take_pre, Pre_Target);
        end
    endtask

    task automatic test_reset_priority();
        logic [31:0] pcs [4];
        train(32'hbfc00020, 1'b1, 32'hbfc00400);
        train(32'hbfc00040, 1'b1, 32'hbfc00500);
        PC_IF = 32'hbfc00040;
        #1;
        checks++;
        if (take_pre !== 1'b1 || Pre_Target !== 32'hbfc00500) begin
            errors++;
            $display("FAIL rstprio_trained got take=%b tgt=%08h want take=1 tgt=bfc00500", take_pre, Pre_Target);
        end
        rst        = 1'b1;
        upd_valid  = 1'b1;
        upd_PC     = 32'hbfc00080;
        upd_taken  = 1'b1;
        upd_target = 32'hbfc00600;
        tick();
        rst       = 1'b0;
        upd_valid = 1'b0;
        upd_taken = 1'b0;
        pcs[0] = 32'hbfc00020;
        pcs[1] = 32'hbfc00040;
        pcs[2] = 32'hbfc00080;
        pcs[3] = 32'hbfc00110;
        for (int i = 0; i < 4; i++) begin
            PC_IF = pcs[i];
            #1;
            checks++;
            if (take_pre !== 1'b0 || Pre_Target !== 32'h0) begin
                errors++;
                $display("FAIL rstprio_cleared pc=%08h got take=%b tgt=%08h want take=0 tgt=00000000",
                         PC_IF, take_pre, Pre_Target);
            end
        end
        // Fresh allocation after reset starts weak-taken
        train(32'hbfc00080, 1'b1, 32'hbfc00604);
        PC_IF = 32'hbfc00080;
        #1;
        checks++;
        if (take_pre !== 1'b1 || Pre_Target !== 32'hbfc00604) begin
            errors++;
            $display("FAIL post_reset_alloc got take=%b tgt=%08h want take=1 tgt=bfc00604", take_pre, Pre_Target);
        end
        train(32'hbfc00080, 1'b0, 32'h0);
        checks++;
        if (take_pre !== 1'b0) begin
            errors++;
            $display("FAIL post_reset_weak got take=%b want take=0", take_pre);
        end
    endtask

    initial begin
        errors     = 0;
        checks     = 0;
        rst        = 1'b0;
        PC_IF      = 32'h0;
        upd_valid  = 1'b0;
        upd_PC     = 32'h0;
        upd_taken  = 1'b0;
        upd_target = 32'h0;
        #2;
        test_reset();
        test_allocate();
        test_saturation();
        test_aliasing();
        test_target_rewrite();
        test_reset_priority();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
